// File: rtl/snoop_bus_pkg.sv
// snoop_bus_pkg: shared widths, bus word field positions, FSM states and arbitration modes
package snoop_bus_pkg;
    localparam int DEF_N_CACHES   = 3;
    localparam int DEF_TAG_W      = 3;
    localparam int DEF_MSG_W      = 3;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_SNOOP_WAIT = 2;
    localparam int DEF_BUS_W      = DEF_TAG_W + DEF_MSG_W + 1 + DEF_DATA_W;
    localparam int DATA_LSB       = 0;
    localparam int VALID_BIT      = DEF_DATA_W;
    localparam int MSG_LSB        = DEF_DATA_W + 1;
    localparam int TAG_LSB        = MSG_LSB + DEF_MSG_W;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BCAST = 3'd1;
    localparam logic [2:0] S_SNOOP = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
endpackage

// File: rtl/snoop_rr_pick.sv
// snoop_rr_pick: circular first-one finder starting at a given index
module snoop_rr_pick
    import snoop_bus_pkg::*;
#(
    parameter int N  = DEF_N_CACHES,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] j;
    always_comb begin
        found = |vec;
        idx = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(start) + k) % N);
            if (vec[j]) idx = j;
        end
    end
endmodule

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: arbitrates caches onto the snoop bus, broadcasts, collects a reply or memory data
module snoop_bus_ctrl
    import snoop_bus_pkg::*;
#(
    parameter int N_CACHES   = DEF_N_CACHES,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int MSG_W      = DEF_MSG_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SNOOP_WAIT = DEF_SNOOP_WAIT,
    parameter int ARB_MODE   = ARB_RR,
    localparam int BUS_W     = TAG_W + MSG_W + 1 + DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CACHES-1:0]       req,
    input  logic [N_CACHES*BUS_W-1:0] em_word,
    input  logic [N_CACHES*BUS_W-1:0] snoop_word,
    input  logic                      mem_rdy,
    input  logic [DATA_W-1:0]         mem_data,
    output logic [N_CACHES-1:0]       grant,
    output logic [BUS_W-1:0]          bus_out,
    output logic                      snoop_en,
    output logic                      mem_req,
    output logic [N_CACHES-1:0]       done,
    output logic                      busy
);
    localparam int IW = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
    localparam int CW = $clog2(SNOOP_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(SNOOP_WAIT - 1);
    logic [2:0] state;
    logic [IW-1:0] owner, rr_ptr, nxt_owner, req_start, req_idx, rsp_idx;
    logic [BUS_W-1:DATA_W] own_hdr;
    logic [CW-1:0] cnt;
    logic req_found, rsp_found, unused;
    logic [N_CACHES-1:0] rsp_v;
    logic [BUS_W-1:0] em_arr [N_CACHES];
    logic [DATA_W-1:0] sn_data [N_CACHES];
    for (genvar g = 0; g < N_CACHES; g++) begin : g_split
        assign em_arr[g]  = em_word[g*BUS_W +: BUS_W];
        assign sn_data[g] = snoop_word[g*BUS_W +: DATA_W];
        assign rsp_v[g]   = snoop_word[g*BUS_W + DATA_W] && (owner != IW'(g));
    end
    assign unused    = ^snoop_word;
    assign nxt_owner = (owner == IW'(N_CACHES - 1)) ? '0 : owner + 1'b1;
    assign req_start = (ARB_MODE == ARB_RR) ? rr_ptr : '0;
    snoop_rr_pick #(.N(N_CACHES), .IW(IW)) u_req_pick (
        .vec(req), .start(req_start), .found(req_found), .idx(req_idx)
    );
    // responders are searched from the slot after the owner so no cache is favoured
    snoop_rr_pick #(.N(N_CACHES), .IW(IW)) u_rsp_pick (
        .vec(rsp_v), .start(nxt_owner), .found(rsp_found), .idx(rsp_idx)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            owner <= '0;
            own_hdr <= '0;
            rr_ptr <= '0;
            cnt <= '0;
            grant <= '0;
            bus_out <= '0;
            snoop_en <= 1'b0;
            mem_req <= 1'b0;
            done <= '0;
            busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_found) begin
                    state <= S_BCAST;
                    owner <= req_idx;
                    own_hdr <= em_arr[req_idx][BUS_W-1:DATA_W];
                    bus_out <= em_arr[req_idx];
                    grant <= N_CACHES'(1) << req_idx;
                    snoop_en <= 1'b1;
                    busy <= 1'b1;
                end
                S_BCAST: begin
                    state <= S_SNOOP;
                    snoop_en <= 1'b0;
                    cnt <= '0;
                end
                S_SNOOP: if (rsp_found) begin
                    state <= S_DONE;
                    bus_out <= {own_hdr[BUS_W-1:DATA_W+1], 1'b1, sn_data[rsp_idx]};
                    done <= grant;
                end else if (cnt == LAST) begin
                    // a valid owner word means the owner already supplies the data
                    state <= own_hdr[DATA_W] ? S_DONE : S_MEM;
                    mem_req <= ~own_hdr[DATA_W];
                    done <= own_hdr[DATA_W] ? grant : '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_MEM: if (mem_rdy) begin
                    state <= S_DONE;
                    mem_req <= 1'b0;
                    bus_out <= {own_hdr[BUS_W-1:DATA_W+1], 1'b1, mem_data};
                    done <= grant;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done <= '0;
                    grant <= '0;
                    bus_out <= '0;
                    busy <= 1'b0;
                    if (ARB_MODE == ARB_RR) rr_ptr <= nxt_owner;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl: directed scoreboard bench for both arbitration modes of snoop_bus_ctrl
module tb_snoop_bus_ctrl;
    localparam int N = 3;
    localparam int BW = 15;
    localparam int SW = 2;
    logic clk = 1'b0;
    logic rst_a, rst_b, sel, mem_rdy;
    logic [N-1:0] req;
    logic [N*BW-1:0] em_word, snoop_word;
    logic [7:0] mem_data;
    logic [N-1:0] grant_a, done_a, grant_b, done_b, grant, done;
    logic [BW-1:0] bus_a, bus_b, bus_out;
    logic sn_a, sn_b, mr_a, mr_b, busy_a, busy_b, snoop_en, mem_req, busy;
    typedef struct {
        logic [N-1:0]  own;
        logic [BW-1:0] bus;
        int            lat;
    } exp_t;
    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snoop_bus_ctrl dut_rr (
        .clk(clk), .reset(rst_a), .req(req), .em_word(em_word), .snoop_word(snoop_word),
        .mem_rdy(mem_rdy), .mem_data(mem_data), .grant(grant_a), .bus_out(bus_a),
        .snoop_en(sn_a), .mem_req(mr_a), .done(done_a), .busy(busy_a)
    );
    snoop_bus_ctrl #(.ARB_MODE(1)) dut_fp (
        .clk(clk), .reset(rst_b), .req(req), .em_word(em_word), .snoop_word(snoop_word),
        .mem_rdy(mem_rdy), .mem_data(mem_data), .grant(grant_b), .bus_out(bus_b),
        .snoop_en(sn_b), .mem_req(mr_b), .done(done_b), .busy(busy_b)
    );

    assign grant    = sel ? grant_b : grant_a;
    assign done     = sel ? done_b : done_a;
    assign bus_out  = sel ? bus_b : bus_a;
    assign snoop_en = sel ? sn_b : sn_a;
    assign mem_req  = sel ? mr_b : mr_a;
    assign busy     = sel ? busy_b : busy_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] w(input logic [2:0] t, input logic [2:0] m, input logic v, input logic [7:0] d);
        return {t, m, v, d};
    endfunction

    task automatic set_em(input int i, input logic [BW-1:0] x);
        em_word[i*BW +: BW] = x;
    endtask

    task automatic set_sn(input int i, input logic [BW-1:0] x);
        snoop_word[i*BW +: BW] = x;
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bus"}, bus_out, 0);
        check({tag, "_snoop_en"}, snoop_en, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // drives req in an IDLE cycle (cycle 0) and follows the transaction to its DONE cycle
    task automatic run(input logic [N-1:0] r, input logic [N-1:0] own, input logic [BW-1:0] bus,
                       input int lat, input bit mem, input int rdy_cyc, input bit keep);
        exp_t e;
        e.own = own;
        e.bus = bus;
        e.lat = lat;
        sbq.push_back(e);
        req = r;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check("grant", grant, own);
            check("snoop_en", snoop_en, c == 1);
            check("mem_req", mem_req, mem && c >= 2 + SW && c < lat);
            check("busy", busy, 1);
            if (done !== '0 && sbq.size() > 0) begin
                e = sbq.pop_front();
                check("done", done, e.own);
                check("bus_out", bus_out, e.bus);
                check("latency", c, e.lat);
            end
            mem_rdy = (c == rdy_cyc);
        end
        check("pending", sbq.size(), 0);
        sbq.delete();
        if (!keep) req = '0;
        @(negedge clk);
        idle_check("after_done");
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        sel = 1'b0;
        req = '0;
        mem_rdy = 1'b0;
        mem_data = 8'hC3;
        em_word = '0;
        snoop_word = '0;
        repeat (2) @(negedge clk);
        idle_check("reset");
        rst_a = 1'b0;
        @(negedge clk);

        // read miss served by memory, mem_rdy two cycles after mem_req rises
        set_em(1, w(3'd5, 3'd1, 1'b0, 8'h00));
        run(3'b010, 3'b010, w(3'd5, 3'd1, 1'b1, 8'hC3), 7, 1, 6, 0);

        // cache-to-cache: owner's own valid reply ignored, first responder after owner wins
        set_em(0, w(3'd2, 3'd3, 1'b0, 8'h00));
        set_sn(0, w(3'd0, 3'd0, 1'b1, 8'hFF));
        set_sn(1, w(3'd0, 3'd0, 1'b1, 8'hA5));
        set_sn(2, w(3'd0, 3'd0, 1'b1, 8'h3C));
        run(3'b001, 3'b001, w(3'd2, 3'd3, 1'b1, 8'hA5), 3, 0, 0, 0);
        set_em(1, w(3'd6, 3'd2, 1'b0, 8'h00));
        run(3'b010, 3'b010, w(3'd6, 3'd2, 1'b1, 8'h3C), 3, 0, 0, 0);

        // write-back: owner word valid, no replies, no memory read
        snoop_word = '0;
        set_em(2, w(3'd7, 3'd4, 1'b1, 8'h77));
        run(3'b100, 3'b100, w(3'd7, 3'd4, 1'b1, 8'h77), 2 + SW, 0, 0, 0);

        // round-robin with req held high
        for (int k = 0; k < N; k++) set_em(k, w(3'(k), 3'(k), 1'b1, 8'(8'h10 + k)));
        run(3'b111, 3'b001, w(3'd0, 3'd0, 1'b1, 8'h10), 2 + SW, 0, 0, 1);
        run(3'b111, 3'b010, w(3'd1, 3'd1, 1'b1, 8'h11), 2 + SW, 0, 0, 1);
        run(3'b111, 3'b100, w(3'd2, 3'd2, 1'b1, 8'h12), 2 + SW, 0, 0, 1);
        run(3'b111, 3'b001, w(3'd0, 3'd0, 1'b1, 8'h10), 2 + SW, 0, 0, 0);

        // reset while waiting on memory; round-robin pointer must restart at 0
        set_em(0, w(3'd1, 3'd2, 1'b0, 8'h00));
        req = 3'b001;
        for (int c = 1; c <= 2 + SW; c++) @(negedge clk);
        check("pre_reset_mem_req", mem_req, 1);
        check("pre_reset_grant", grant, 3'b001);
        rst_a = 1'b1;
        req = '0;
        @(negedge clk);
        idle_check("mid_mem_reset");
        rst_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_reset_done", done, 0);
        end
        set_em(0, w(3'd1, 3'd2, 1'b1, 8'h5A));
        run(3'b111, 3'b001, w(3'd1, 3'd2, 1'b1, 8'h5A), 2 + SW, 0, 0, 0);

        // fixed priority instance: every grant goes to cache 0
        rst_a = 1'b1;
        rst_b = 1'b0;
        sel = 1'b1;
        set_em(0, w(3'd0, 3'd0, 1'b1, 8'h10));
        @(negedge clk);
        idle_check("fp_start");
        run(3'b111, 3'b001, w(3'd0, 3'd0, 1'b1, 8'h10), 2 + SW, 0, 0, 1);
        run(3'b111, 3'b001, w(3'd0, 3'd0, 1'b1, 8'h10), 2 + SW, 0, 0, 1);
        run(3'b111, 3'b001, w(3'd0, 3'd0, 1'b1, 8'h10), 2 + SW, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
